// File: rtl/calc2.sv
`default_nettype none
// ============================================================================
//  Module   : calc2
//  Purpose  : Four-port tagged 32-bit calculator. Each port has a capture
//             stage and a 4-deep in-order command queue. One shared add/sub
//             unit and one shared shift unit are arbitrated with fixed
//             priority (port1 highest). Scan pins carry no function.
//  Revision : 1.0  initial release
// ============================================================================
module calc2 (
   input  logic        c_clk,
   input  logic        reset,
   input  logic [3:0]  req1_cmd_in,
   input  logic [31:0] req1_data_in,
   input  logic [1:0]  req1_tag_in,
   input  logic [3:0]  req2_cmd_in,
   input  logic [31:0] req2_data_in,
   input  logic [1:0]  req2_tag_in,
   input  logic [3:0]  req3_cmd_in,
   input  logic [31:0] req3_data_in,
   input  logic [1:0]  req3_tag_in,
   input  logic [3:0]  req4_cmd_in,
   input  logic [31:0] req4_data_in,
   input  logic [1:0]  req4_tag_in,
   output logic [31:0] out_data1,
   output logic [1:0]  out_resp1,
   output logic [1:0]  out_tag1,
   output logic [31:0] out_data2,
   output logic [1:0]  out_resp2,
   output logic [1:0]  out_tag2,
   output logic [31:0] out_data3,
   output logic [1:0]  out_resp3,
   output logic [1:0]  out_tag3,
   output logic [31:0] out_data4,
   output logic [1:0]  out_resp4,
   output logic [1:0]  out_tag4,
   input  logic        scan_in,
   input  logic        a_clk,
   input  logic        b_clk,
   output logic        scan_out
);

   localparam int         NP       = 4;
   localparam logic [2:0] MAX_OUT  = 3'd4;
   localparam logic [3:0] CMD_ADD  = 4'd1;
   localparam logic [3:0] CMD_SUB  = 4'd2;
   localparam logic [3:0] CMD_SHL  = 4'd5;
   localparam logic [3:0] CMD_SHR  = 4'd6;
   localparam logic [1:0] RESP_OK  = 2'd1;
   localparam logic [1:0] RESP_ERR = 2'd2;

   typedef struct packed {
      logic [3:0]  cmd;
      logic [1:0]  tag;
      logic [31:0] op1;
      logic [31:0] op2;
   } entry_t;

   // Port-indexed views of the flat port list
   logic [3:0]  cmd_in   [NP];
   logic [31:0] data_in  [NP];
   logic [1:0]  tag_in   [NP];
   logic [31:0] res_data [NP];
   logic [1:0]  res_resp [NP];
   logic [1:0]  res_tag  [NP];

   assign cmd_in[0] = req1_cmd_in;   assign data_in[0] = req1_data_in;   assign tag_in[0] = req1_tag_in;
   assign cmd_in[1] = req2_cmd_in;   assign data_in[1] = req2_data_in;   assign tag_in[1] = req2_tag_in;
   assign cmd_in[2] = req3_cmd_in;   assign data_in[2] = req3_data_in;   assign tag_in[2] = req3_tag_in;
   assign cmd_in[3] = req4_cmd_in;   assign data_in[3] = req4_data_in;   assign tag_in[3] = req4_tag_in;

   assign out_data1 = res_data[0];   assign out_resp1 = res_resp[0];   assign out_tag1 = res_tag[0];
   assign out_data2 = res_data[1];   assign out_resp2 = res_resp[1];   assign out_tag2 = res_tag[1];
   assign out_data3 = res_data[2];   assign out_resp3 = res_resp[2];   assign out_tag3 = res_tag[2];
   assign out_data4 = res_data[3];   assign out_resp4 = res_resp[3];   assign out_tag4 = res_tag[3];

   // Scan pins are present for integration and carry no function
   logic unused_scan_pins;
   assign unused_scan_pins = scan_in ^ a_clk ^ b_clk;
   assign scan_out         = 1'b0;

   // Capture stage: command cycle latches cmd/tag/op1, next cycle supplies op2
   logic        pend_v   [NP];
   logic [3:0]  pend_cmd [NP];
   logic [1:0]  pend_tag [NP];
   logic [31:0] pend_op1 [NP];

   // Per-port queues and outstanding-command counters
   entry_t      fifo_mem [NP][4];
   logic [1:0]  wr_ptr   [NP];
   logic [1:0]  rd_ptr   [NP];
   logic [2:0]  fifo_cnt [NP];
   logic [2:0]  outst    [NP];

   // Queue-head decode and per-port handshakes
   entry_t      head     [NP];
   logic        is_add   [NP];
   logic        is_sh    [NP];
   logic        is_inv   [NP];
   logic        accept   [NP];
   logic        pop      [NP];
   logic        done     [NP];

   // Arbitration results
   logic        add_gnt_v;
   logic [1:0]  add_gnt;
   logic        sh_gnt_v;
   logic [1:0]  sh_gnt;

   // Unit input registers (dispatch stage)
   logic        add_v;
   logic [1:0]  add_port;
   logic        add_is_sub;
   logic [31:0] add_a;
   logic [31:0] add_b;
   logic [1:0]  add_tag;
   logic        sh_v;
   logic [1:0]  sh_port;
   logic        sh_left;
   logic [31:0] sh_a;
   logic [4:0]  sh_amt;
   logic [1:0]  sh_tag;
   logic        inv_v    [NP];
   logic [1:0]  inv_tag  [NP];

   // Decode each queue head and decide whether a new command may be accepted
   always_comb begin
      for (int p = 0; p < NP; p++) begin
         head[p]   = fifo_mem[p][rd_ptr[p]];
         is_add[p] = (fifo_cnt[p] != 3'd0) &&
                     (head[p].cmd == CMD_ADD || head[p].cmd == CMD_SUB);
         is_sh[p]  = (fifo_cnt[p] != 3'd0) &&
                     (head[p].cmd == CMD_SHL || head[p].cmd == CMD_SHR);
         is_inv[p] = (fifo_cnt[p] != 3'd0) && !is_add[p] && !is_sh[p];
         // The op2 cycle is never a command cycle, whatever cmd shows
         accept[p] = !pend_v[p] && (cmd_in[p] != 4'd0) && (outst[p] < MAX_OUT);
      end
   end

   // Fixed-priority arbitration per unit; invalid heads retire on their own path
   always_comb begin
      add_gnt_v = 1'b0;
      add_gnt   = 2'd0;
      sh_gnt_v  = 1'b0;
      sh_gnt    = 2'd0;
      // Scan from lowest priority so the highest-priority requester wins last
      for (int p = NP - 1; p >= 0; p--) begin
         if (is_add[p]) begin
            add_gnt_v = 1'b1;
            add_gnt   = 2'(p);
         end
         if (is_sh[p]) begin
            sh_gnt_v = 1'b1;
            sh_gnt   = 2'(p);
         end
      end
      for (int p = 0; p < NP; p++) begin
         pop[p]  = is_inv[p] ||
                   (add_gnt_v && add_gnt == 2'(p)) ||
                   (sh_gnt_v  && sh_gnt  == 2'(p));
         done[p] = inv_v[p] ||
                   (add_v && add_port == 2'(p)) ||
                   (sh_v  && sh_port  == 2'(p));
      end
   end

   // Shared execution units
   logic [32:0] add_sum;
   logic [31:0] sub_dif;
   logic        add_bad;
   logic [31:0] add_res;
   logic [31:0] sh_res;

   assign add_sum = {1'b0, add_a} + {1'b0, add_b};
   assign sub_dif = add_a - add_b;
   assign add_bad = add_is_sub ? (add_b > add_a) : add_sum[32];
   assign add_res = add_bad ? 32'd0 : (add_is_sub ? sub_dif : add_sum[31:0]);
   assign sh_res  = sh_left ? (sh_a << sh_amt) : (sh_a >> sh_amt);

   // Control state: capture valid, queue pointers, counters, dispatch valids
   always_ff @(posedge c_clk) begin
      if (reset) begin
         for (int p = 0; p < NP; p++) begin
            pend_v[p]   <= 1'b0;
            wr_ptr[p]   <= 2'd0;
            rd_ptr[p]   <= 2'd0;
            fifo_cnt[p] <= 3'd0;
            outst[p]    <= 3'd0;
            inv_v[p]    <= 1'b0;
         end
         add_v <= 1'b0;
         sh_v  <= 1'b0;
      end else begin
         for (int p = 0; p < NP; p++) begin
            pend_v[p] <= accept[p];
            if (pend_v[p]) wr_ptr[p] <= wr_ptr[p] + 2'd1;
            if (pop[p])    rd_ptr[p] <= rd_ptr[p] + 2'd1;
            fifo_cnt[p] <= fifo_cnt[p] + {2'b00, pend_v[p]} - {2'b00, pop[p]};
            outst[p]    <= outst[p] + {2'b00, accept[p]} - {2'b00, done[p]};
            inv_v[p]    <= is_inv[p];
         end
         add_v <= add_gnt_v;
         sh_v  <= sh_gnt_v;
      end
   end

   // Datapath registers: qualified by the valids above, so no reset needed
   always_ff @(posedge c_clk) begin
      for (int p = 0; p < NP; p++) begin
         if (accept[p]) begin
            pend_cmd[p] <= cmd_in[p];
            pend_tag[p] <= tag_in[p];
            pend_op1[p] <= data_in[p];
         end
         if (pend_v[p]) begin
            fifo_mem[p][wr_ptr[p]] <= {pend_cmd[p], pend_tag[p], pend_op1[p], data_in[p]};
         end
         inv_tag[p] <= head[p].tag;
      end
      add_port   <= add_gnt;
      add_is_sub <= (head[add_gnt].cmd == CMD_SUB);
      add_a      <= head[add_gnt].op1;
      add_b      <= head[add_gnt].op2;
      add_tag    <= head[add_gnt].tag;
      sh_port    <= sh_gnt;
      sh_left    <= (head[sh_gnt].cmd == CMD_SHL);
      sh_a       <= head[sh_gnt].op1;
      sh_amt     <= head[sh_gnt].op2[4:0];
      sh_tag     <= head[sh_gnt].tag;
   end

   // Response registers: at most one source targets a port in any cycle
   always_ff @(posedge c_clk) begin
      for (int p = 0; p < NP; p++) begin
         if (reset) begin
            res_resp[p] <= 2'd0;
            res_data[p] <= 32'd0;
            res_tag[p]  <= 2'd0;
         end else if (add_v && add_port == 2'(p)) begin
            res_resp[p] <= add_bad ? RESP_ERR : RESP_OK;
            res_data[p] <= add_res;
            res_tag[p]  <= add_tag;
         end else if (sh_v && sh_port == 2'(p)) begin
            res_resp[p] <= RESP_OK;
            res_data[p] <= sh_res;
            res_tag[p]  <= sh_tag;
         end else if (inv_v[p]) begin
            res_resp[p] <= RESP_ERR;
            res_data[p] <= 32'd0;
            res_tag[p]  <= inv_tag[p];
         end else begin
            res_resp[p] <= 2'd0;
            res_data[p] <= 32'd0;
            res_tag[p]  <= 2'd0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_calc2.sv
`default_nettype none
// ============================================================================
//  Module   : tb_calc2
//  Purpose  : Self-checking bench for calc2: directed vector table plus
//             hand-written sequences for reset, contention and the
//             outstanding-command limit.
//  Revision : 1.0  initial release
// ============================================================================
module tb_calc2;

   typedef struct {
      int          port;
      logic [3:0]  cmd;
      logic [1:0]  tag;
      logic [31:0] op1;
      logic [31:0] op2;
      logic [1:0]  eresp;
      logic [31:0] edata;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  cmd  [4];
   logic [31:0] din  [4];
   logic [1:0]  tin  [4];
   logic [31:0] dout [4];
   logic [1:0]  resp [4];
   logic [1:0]  tout [4];
   logic        scan_out;

   int n_cmp = 0;
   int n_bad = 0;

   logic        mon_en = 1'b0;
   logic [35:0] mon_q [$];

   always #5 clk = ~clk;

   calc2 dut (
      .c_clk        (clk),
      .reset        (rst),
      .req1_cmd_in  (cmd[0]), .req1_data_in (din[0]), .req1_tag_in (tin[0]),
      .req2_cmd_in  (cmd[1]), .req2_data_in (din[1]), .req2_tag_in (tin[1]),
      .req3_cmd_in  (cmd[2]), .req3_data_in (din[2]), .req3_tag_in (tin[2]),
      .req4_cmd_in  (cmd[3]), .req4_data_in (din[3]), .req4_tag_in (tin[3]),
      .out_data1    (dout[0]), .out_resp1 (resp[0]), .out_tag1 (tout[0]),
      .out_data2    (dout[1]), .out_resp2 (resp[1]), .out_tag2 (tout[1]),
      .out_data3    (dout[2]), .out_resp3 (resp[2]), .out_tag3 (tout[2]),
      .out_data4    (dout[3]), .out_resp4 (resp[3]), .out_tag4 (tout[3]),
      .scan_in      (1'b0),
      .a_clk        (1'b0),
      .b_clk        (1'b0),
      .scan_out     (scan_out)
   );

   // Collect every response on port 3 while the limit test runs
   always @(posedge clk) begin
      #1;
      if (mon_en && resp[2] != 2'd0) mon_q.push_back({2'b00, resp[2], tout[2], dout[2]});
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual %h required %h", name, act, exp);
      end
   endtask

   task automatic idle_all();
      for (int p = 0; p < 4; p++) begin
         cmd[p] = 4'd0;
         din[p] = 32'd0;
         tin[p] = 2'd0;
      end
   endtask

   // Issue one command on an otherwise idle machine and check exact latency
   task automatic run_one(input string name, input int p, input logic [3:0] c,
                          input logic [1:0] t, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] er, input logic [31:0] ed);
      cmd[p] = c; tin[p] = t; din[p] = a;
      tick();                                   // E0
      cmd[p] = 4'd0; tin[p] = 2'd0; din[p] = b;
      tick();                                   // E0+1
      din[p] = 32'd0;
      tick();                                   // E0+2
      check({name, "_early"}, 36'(resp[p]), 36'd0);
      tick();                                   // E0+3
      check({name, "_resp"}, 36'(resp[p]), 36'(er));
      check({name, "_data"}, 36'(dout[p]), 36'(ed));
      check({name, "_tag"},  36'(tout[p]), 36'(t));
      tick();
      check({name, "_pulse"}, 36'(resp[p]), 36'd0);
   endtask

   vec_t vecs [12];

   initial begin
      vecs[0]  = '{0, 4'd1,  2'd2, 32'h0000_0005, 32'h0000_0007, 2'd1, 32'h0000_000C};
      vecs[1]  = '{0, 4'd1,  2'd0, 32'hFFFF_FFFF, 32'h0000_0001, 2'd2, 32'h0000_0000};
      vecs[2]  = '{0, 4'd2,  2'd1, 32'h0000_0003, 32'h0000_0005, 2'd2, 32'h0000_0000};
      vecs[3]  = '{0, 4'd2,  2'd3, 32'h0000_0005, 32'h0000_0005, 2'd1, 32'h0000_0000};
      vecs[4]  = '{1, 4'd5,  2'd0, 32'h8000_0001, 32'h0000_0021, 2'd1, 32'h0000_0002};
      vecs[5]  = '{1, 4'd6,  2'd1, 32'h8000_0000, 32'h0000_001F, 2'd1, 32'h0000_0001};
      vecs[6]  = '{3, 4'd3,  2'd1, 32'h0000_DEAD, 32'h0000_BEEF, 2'd2, 32'h0000_0000};
      vecs[7]  = '{2, 4'd2,  2'd2, 32'h0000_000A, 32'h0000_0003, 2'd1, 32'h0000_0007};
      vecs[8]  = '{1, 4'd5,  2'd3, 32'h0000_0001, 32'h0000_001F, 2'd1, 32'h8000_0000};
      vecs[9]  = '{3, 4'd15, 2'd3, 32'h1234_5678, 32'h0000_0001, 2'd2, 32'h0000_0000};
      vecs[10] = '{2, 4'd1,  2'd1, 32'h7FFF_FFFF, 32'h8000_0000, 2'd1, 32'hFFFF_FFFF};
      vecs[11] = '{0, 4'd6,  2'd0, 32'h1234_5678, 32'h0000_0104, 2'd1, 32'h0123_4567};

      // Reset with random inputs: outputs must stay zero
      rst = 1'b1;
      idle_all();
      for (int c = 0; c < 5; c++) begin
         for (int p = 0; p < 4; p++) begin
            cmd[p] = 4'($urandom);
            din[p] = $urandom;
            tin[p] = 2'($urandom);
         end
         tick();
         for (int p = 0; p < 4; p++)
            check($sformatf("reset_out_p%0d", p + 1), {resp[p], tout[p], dout[p]}, 36'd0);
         check("reset_scan_out", 36'(scan_out), 36'd0);
      end
      rst = 1'b0;
      idle_all();

      // Directed vectors; the first one is issued on the first edge after reset
      for (int i = 0; i < 12; i++)
         run_one($sformatf("vec%0d", i), vecs[i].port, vecs[i].cmd, vecs[i].tag,
                 vecs[i].op1, vecs[i].op2, vecs[i].eresp, vecs[i].edata);

      // Reset mid-operation discards the in-flight command
      cmd[0] = 4'd1; din[0] = 32'd9; tin[0] = 2'd3;
      tick();
      cmd[0] = 4'd0; din[0] = 32'd1; tin[0] = 2'd0;
      tick();
      din[0] = 32'd0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         check("midreset_quiet", {28'd0, resp[0], resp[1], resp[2], resp[3]}, 36'd0);
      end
      run_one("after_midreset", 0, 4'd1, 2'd1, 32'd20, 32'd22, 2'd1, 32'd42);

      // All four ports add in the same cycle: responses at +3..+6
      for (int p = 0; p < 4; p++) begin
         cmd[p] = 4'd1; tin[p] = 2'(p); din[p] = 32'(p + 1);
      end
      tick();
      for (int p = 0; p < 4; p++) begin
         cmd[p] = 4'd0; tin[p] = 2'd0; din[p] = 32'(10 * (p + 1));
      end
      tick();
      idle_all();
      for (int k = 2; k <= 7; k++) begin
         tick();
         for (int p = 0; p < 4; p++) begin
            check($sformatf("cont4_resp_p%0d_e%0d", p + 1, k), 36'(resp[p]),
                  (k == p + 3) ? 36'd1 : 36'd0);
            if (k == p + 3) begin
               check($sformatf("cont4_data_p%0d", p + 1), 36'(dout[p]), 36'(11 * (p + 1)));
               check($sformatf("cont4_tag_p%0d", p + 1), 36'(tout[p]), 36'(p));
            end
         end
      end

      // Shift on port 1 and add on port 2 use different units: both at +3
      cmd[0] = 4'd5; tin[0] = 2'd1; din[0] = 32'h3;
      cmd[1] = 4'd1; tin[1] = 2'd2; din[1] = 32'h1;
      tick();
      cmd[0] = 4'd0; tin[0] = 2'd0; din[0] = 32'h2;
      cmd[1] = 4'd0; tin[1] = 2'd0; din[1] = 32'h2;
      tick();
      idle_all();
      tick();
      check("dual_early", {32'd0, resp[0], resp[1]}, 36'd0);
      tick();
      check("dual_p1", {resp[0], tout[0], dout[0]}, {2'd1, 2'd1, 32'hC});
      check("dual_p2", {resp[1], tout[1], dout[1]}, {2'd1, 2'd2, 32'h3});

      // Outstanding limit: ports 1 and 2 saturate the adder, port 3 queues up
      mon_q.delete();
      mon_en = 1'b1;
      for (int c = 0; c < 22; c++) begin
         cmd[0] = (c % 2 == 0 && c < 20) ? 4'd1 : 4'd0;
         din[0] = (c % 2 == 0) ? 32'd1 : 32'd2;
         cmd[1] = (c % 2 == 1 && c < 21) ? 4'd1 : 4'd0;
         din[1] = (c % 2 == 1) ? 32'd3 : 32'd4;
         if (c < 10 && c % 2 == 0) begin
            cmd[2] = 4'd1; tin[2] = 2'((c / 2) % 4); din[2] = 32'(100 + c);
         end else begin
            cmd[2] = 4'd0; tin[2] = 2'd0; din[2] = 32'd1;
         end
         tick();
      end
      idle_all();
      for (int k = 0; k < 20; k++) tick();
      mon_en = 1'b0;
      check("limit_count", 36'(mon_q.size()), 36'd4);
      for (int i = 0; i < 4; i++) begin
         if (i < mon_q.size())
            check($sformatf("limit_rsp%0d", i), mon_q[i],
                  {2'b00, 2'd1, 2'(i), 32'(101 + 2 * i)});
      end
      // Counter must have drained back so port 3 accepts again
      run_one("after_limit", 2, 4'd1, 2'd2, 32'd4, 32'd5, 2'd1, 32'd9);

      check("final_scan_out", 36'(scan_out), 36'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
